// File: rtl/dff_mon_pkg.sv
// Shared types and helpers for the DFF edge monitor and its sub-blocks.
package dff_mon_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2
  } mon_state_t;

  // All-ones value of a w-bit counter, used as the saturation limit.
  function automatic logic [31:0] cnt_all_ones(input int unsigned w);
    if (w >= 32'd32) begin
      return 32'hFFFF_FFFF;
    end else begin
      return (32'd1 << w) - 32'd1;
    end
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic s1_r;

  // Metastability chain: d -> s1_r -> q
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_r <= 1'b0;
      q    <= 1'b0;
    end else begin
      s1_r <= d;
      q    <= s1_r;
    end
  end

endmodule

// File: rtl/dff_edge_monitor.sv
// Watches the DFF q output: resynchronises it, pulses on each edge, counts rises
// and measures every complete high pulse, flagging those shorter than MIN_WIDTH.
module dff_edge_monitor
  import dff_mon_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int MIN_WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             q_in,
  input  logic             clr,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] width_last,
  output logic             width_valid,
  output logic             short_pulse
);

  localparam logic [CNT_W-1:0] SAT   = CNT_W'(cnt_all_ones(CNT_W));
  localparam logic [CNT_W-1:0] MIN_W = CNT_W'(MIN_WIDTH);
  localparam logic [CNT_W-1:0] ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             s2_s;
  logic             s3_r;
  logic             rise_ev_s;
  logic             fall_ev_s;
  mon_state_t       state_r;
  mon_state_t       state_nxt_s;
  logic [CNT_W-1:0] wcnt_r;
  logic [CNT_W-1:0] wcnt_nxt_s;
  logic [CNT_W-1:0] rise_cnt_nxt_s;
  logic [CNT_W-1:0] width_last_nxt_s;
  logic             rise_pulse_nxt_s;
  logic             fall_pulse_nxt_s;
  logic             width_valid_nxt_s;
  logic             short_pulse_nxt_s;

  sync_2ff u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (q_in),
    .q       (s2_s)
  );

  // History flop behind the synchroniser; clr leaves it alone so in-flight edges survive
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s3_r <= 1'b0;
    end else begin
      s3_r <= s2_s;
    end
  end

  assign rise_ev_s = s2_s & ~s3_r;
  assign fall_ev_s = ~s2_s & s3_r;

  // Next-state, counter and strobe decode; clr overrides any event
  always_comb begin
    state_nxt_s       = state_r;
    wcnt_nxt_s        = wcnt_r;
    rise_cnt_nxt_s    = rise_cnt;
    width_last_nxt_s  = width_last;
    rise_pulse_nxt_s  = 1'b0;
    fall_pulse_nxt_s  = 1'b0;
    width_valid_nxt_s = 1'b0;
    short_pulse_nxt_s = 1'b0;
    if (clr) begin
      state_nxt_s      = S_IDLE;
      wcnt_nxt_s       = ZERO;
      rise_cnt_nxt_s   = ZERO;
      width_last_nxt_s = ZERO;
    end else begin
      rise_pulse_nxt_s = rise_ev_s;
      fall_pulse_nxt_s = fall_ev_s;
      if (rise_ev_s && (rise_cnt != SAT)) begin
        rise_cnt_nxt_s = rise_cnt + ONE;
      end else begin
        rise_cnt_nxt_s = rise_cnt;
      end
      case (state_r)
        S_IDLE: begin
          if (rise_ev_s) begin
            state_nxt_s = S_HIGH;
            wcnt_nxt_s  = ONE;
          end else if (fall_ev_s) begin
            state_nxt_s = S_LOW;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        S_HIGH: begin
          if (fall_ev_s) begin
            state_nxt_s       = S_LOW;
            wcnt_nxt_s        = ZERO;
            width_last_nxt_s  = wcnt_r;
            width_valid_nxt_s = 1'b1;
            short_pulse_nxt_s = (wcnt_r < MIN_W);
          end else if (wcnt_r != SAT) begin
            wcnt_nxt_s = wcnt_r + ONE;
          end else begin
            wcnt_nxt_s = wcnt_r;
          end
        end
        S_LOW: begin
          if (rise_ev_s) begin
            state_nxt_s = S_HIGH;
            wcnt_nxt_s  = ONE;
          end else begin
            state_nxt_s = S_LOW;
          end
        end
        default: begin
          state_nxt_s = S_IDLE;
          wcnt_nxt_s  = ZERO;
        end
      endcase
    end
  end

  // State, width counter and all registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= S_IDLE;
      wcnt_r      <= ZERO;
      rise_cnt    <= ZERO;
      width_last  <= ZERO;
      rise_pulse  <= 1'b0;
      fall_pulse  <= 1'b0;
      width_valid <= 1'b0;
      short_pulse <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      wcnt_r      <= wcnt_nxt_s;
      rise_cnt    <= rise_cnt_nxt_s;
      width_last  <= width_last_nxt_s;
      rise_pulse  <= rise_pulse_nxt_s;
      fall_pulse  <= fall_pulse_nxt_s;
      width_valid <= width_valid_nxt_s;
      short_pulse <= short_pulse_nxt_s;
    end
  end

endmodule

// File: tb/tb_dff_edge_monitor.sv
// Self-checking bench: two monitor instances (8-bit and 4-bit counters) against a
// run-length reference model of the sampled q_in history.
module tb_dff_edge_monitor;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       q_in;
  logic       clr;
  logic       rp8, fp8, wv8, sp8;
  logic [7:0] rc8, wl8;
  logic       rp4, fp4, wv4, sp4;
  logic [3:0] rc4, wl4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dff_edge_monitor #(.CNT_W(8), .MIN_WIDTH(3)) dut8 (
    .clk(clk), .reset_n(reset_n), .q_in(q_in), .clr(clr),
    .rise_pulse(rp8), .fall_pulse(fp8), .rise_cnt(rc8), .width_last(wl8),
    .width_valid(wv8), .short_pulse(sp8)
  );

  dff_edge_monitor #(.CNT_W(4), .MIN_WIDTH(3)) dut4 (
    .clk(clk), .reset_n(reset_n), .q_in(q_in), .clr(clr),
    .rise_pulse(rp4), .fall_pulse(fp4), .rise_cnt(rc4), .width_last(wl4),
    .width_valid(wv4), .short_pulse(sp4)
  );

  // Reference model: q_in value sampled at each clock edge since reset release,
  // preceded by three zeros standing for the cleared pipeline.
  bit hist[$];
  int sat[2] = '{255, 15};
  int m_rcnt[2];
  int m_wl[2];
  bit m_wv[2];
  bit m_sp[2];
  bit m_rp, m_fp, m_armed;
  int m_rise_at;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    repeat (3) hist.push_back(1'b0);
    m_armed = 1'b0; m_rise_at = 0; m_rp = 1'b0; m_fp = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_rcnt[i] = 0; m_wl[i] = 0; m_wv[i] = 1'b0; m_sp[i] = 1'b0;
    end
  endtask

  // An edge in the sampled history appears on the outputs two clocks later;
  // a width is the distance between the reported rise and fall.
  task automatic model_step();
    int k;
    bit r, f;
    hist.push_back(q_in);
    k = hist.size() - 1;
    r = hist[k-2] && !hist[k-3];
    f = !hist[k-2] && hist[k-3];
    m_rp = 1'b0; m_fp = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_wv[i] = 1'b0; m_sp[i] = 1'b0;
    end
    if (clr) begin
      m_armed = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_rcnt[i] = 0; m_wl[i] = 0;
      end
    end else begin
      m_rp = r; m_fp = f;
      if (r) begin
        m_armed = 1'b1; m_rise_at = k;
        for (int i = 0; i < 2; i++) m_rcnt[i] = (m_rcnt[i] + 1 > sat[i]) ? sat[i] : m_rcnt[i] + 1;
      end
      if (f && m_armed) begin
        m_armed = 1'b0;
        for (int i = 0; i < 2; i++) begin
          m_wl[i] = (k - m_rise_at > sat[i]) ? sat[i] : k - m_rise_at;
          m_wv[i] = 1'b1;
          m_sp[i] = (m_wl[i] < 3);
        end
      end
    end
  endtask

  task automatic compare_all();
    check_val("rise_pulse8", {31'd0, rp8}, {31'd0, m_rp});
    check_val("fall_pulse8", {31'd0, fp8}, {31'd0, m_fp});
    check_val("rise_cnt8", {24'd0, rc8}, m_rcnt[0]);
    check_val("width_last8", {24'd0, wl8}, m_wl[0]);
    check_val("width_valid8", {31'd0, wv8}, {31'd0, m_wv[0]});
    check_val("short_pulse8", {31'd0, sp8}, {31'd0, m_sp[0]});
    check_val("rise_pulse4", {31'd0, rp4}, {31'd0, m_rp});
    check_val("fall_pulse4", {31'd0, fp4}, {31'd0, m_fp});
    check_val("rise_cnt4", {28'd0, rc4}, m_rcnt[1]);
    check_val("width_last4", {28'd0, wl4}, m_wl[1]);
    check_val("width_valid4", {31'd0, wv4}, {31'd0, m_wv[1]});
    check_val("short_pulse4", {31'd0, sp4}, {31'd0, m_sp[1]});
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_out8"}, {12'd0, rp8, fp8, wv8, sp8, rc8, wl8}, 32'd0);
    check_val({tag, "_out4"}, {20'd0, rp4, fp4, wv4, sp4, rc4, wl4}, 32'd0);
  endtask

  task automatic tick(input bit q, input bit c);
    q_in = q;
    clr  = c;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    reset_n = 1'b0; q_in = 1'b0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset_n = 1'b1;
    model_reset();

    // Basic 5-cycle pulse, then a short 2-cycle pulse
    repeat (4) tick(1'b0, 1'b0);
    repeat (5) tick(1'b1, 1'b0);
    repeat (6) tick(1'b0, 1'b0);
    repeat (2) tick(1'b1, 1'b0);
    repeat (6) tick(1'b0, 1'b0);

    // 17 pulses of 4: the 4-bit rise counter saturates at 15
    repeat (17) begin
      repeat (4) tick(1'b1, 1'b0);
      repeat (4) tick(1'b0, 1'b0);
    end
    check_val("sat_rise_cnt4", {28'd0, rc4}, 32'd15);

    // Long pulse: width saturates
    repeat (300) tick(1'b1, 1'b0);
    repeat (6) tick(1'b0, 1'b0);
    check_val("sat_width8", {24'd0, wl8}, 32'd255);

    // clr coincident with a rise event after three counted rises
    tick(1'b0, 1'b1);
    repeat (4) tick(1'b0, 1'b0);
    repeat (3) begin
      repeat (3) tick(1'b1, 1'b0);
      repeat (4) tick(1'b0, 1'b0);
    end
    check_val("clr_pre_cnt", {24'd0, rc8}, 32'd3);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    check_val("clr_cnt", {24'd0, rc8}, 32'd0);
    check_val("clr_no_rise", {31'd0, rp8}, 32'd0);
    repeat (2) tick(1'b1, 1'b0);
    repeat (6) tick(1'b0, 1'b0);

    // Reset dropped mid-pulse, released with q_in still high
    repeat (3) tick(1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1 check_zero("async_reset");
    repeat (2) @(posedge clk);
    #1;
    check_zero("held_reset");
    reset_n = 1'b1;
    model_reset();
    repeat (6) tick(1'b1, 1'b0);
    repeat (5) tick(1'b0, 1'b0);
    check_val("post_reset_cnt", {24'd0, rc8}, 32'd1);
    check_val("post_reset_width", {24'd0, wl8}, 32'd6);

    // Random pulse trains with occasional clr
    repeat (150) begin
      int hi, lo;
      hi = $urandom_range(1, 7);
      lo = $urandom_range(1, 6);
      repeat (hi) tick(1'b1, $urandom_range(0, 40) == 0);
      repeat (lo) tick(1'b0, $urandom_range(0, 40) == 0);
    end
    repeat (5) tick(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dff_edge_monitor.md
Name: dff_edge_monitor

Overview:
- Downstream consumer of the DFF stage's q output.
- Resynchronises q into the local clock domain and detects rising and falling edges as single-cycle pulses.
- Counts rising edges and measures each high-pulse width in clock cycles.
- Flags pulses shorter than a programmed minimum, so the DFF's set/reset/d behaviour can be checked in-system.

Parameters:
- CNT_W, 8, width of the rise counter and of the width counter/report.
- MIN_WIDTH, 3, a high pulse with width < MIN_WIDTH cycles is reported as short (1 <= MIN_WIDTH <= 2^CNT_W-1).

Ports:
- clk  input  1  single clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- q_in  input  1  DFF q output, treated as asynchronous.
- clr  input  1  synchronous clear of counters, report and FSM.
- rise_pulse  output  1  one-cycle pulse per detected rising edge.
- fall_pulse  output  1  one-cycle pulse per detected falling edge.
- rise_cnt  output  CNT_W  rising edges seen since reset/clr, saturating.
- width_last  output  CNT_W  width in cycles of the most recent complete high pulse.
- width_valid  output  1  one-cycle strobe when width_last updates.
- short_pulse  output  1  one-cycle strobe alongside width_valid when width_last < MIN_WIDTH.

Behaviour:
- Reset (reset_n=0, takes effect immediately, no clock needed):
  - all outputs 0.
  - sync flops s1/s2/s3 = 0.
  - width counter = 0.
  - FSM = S_IDLE.
- Synchroniser: q_in -> s1 -> s2, plus history flop s3 <= s2.
  - Internal events: rise_ev = s2 & ~s3; fall_ev = ~s2 & s3.
- Latency: if q_in is first sampled high at edge E0:
  - rise_ev is true after E1.
  - rise_pulse, the FSM transition and the rise_cnt increment are registered at E2.
  - Falling edges have identical latency.
- FSM states (typedef in package):
  - S_IDLE:
    - on rise_ev -> S_HIGH, width counter = 1.
    - on fall_ev -> S_LOW, no width report.
  - S_HIGH:
    - width counter += 1 per cycle, saturating at 2^CNT_W-1.
    - on fall_ev -> S_LOW; width_last = width counter; width_valid = 1; short_pulse = (width counter < MIN_WIDTH).
  - S_LOW:
    - on rise_ev -> S_HIGH, width counter = 1.
- Width rule: q_in sampled high on exactly N consecutive edges gives width_last = N, reported at edge E(N+2) in the same cycle as fall_pulse.
- rise_pulse / fall_pulse are asserted on every detected edge, including in S_IDLE.
- rise_cnt increments on each rise_ev and saturates at 2^CNT_W-1; it does not wrap.
- width_last holds its value until the next report, clr or reset.
- clr=1 (synchronous), highest priority over any event in the same cycle:
  - rise_cnt, width_last, width counter and all strobes go to 0; FSM = S_IDLE.
  - Sync flops are NOT cleared, so an edge already in flight after clr is still detected.
- Level high when leaving reset: s2 rises from 0, so this counts as a rise. This is intended; a DFF held set during reset shows one rise.
- reset_n deassertion is synchronised externally; no intra-block handling is required.

Decomposition:
- Package dff_mon_pkg holds:
  - typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} mon_state_t.
  - Localparam SAT helper function for the all-ones value of CNT_W.
- Sub-module sync_2ff: 2-flop synchroniser with asynchronous active-low reset, reused by later blocks.
- Edge detect, counters and FSM stay in dff_edge_monitor.

Test Plan:
- Release reset, q_in=0, then q_in=1 for 5 cycles, then 0 -> rise_pulse once, rise_cnt=1, fall_pulse with width_valid=1, width_last=5, short_pulse=0.
- q_in=1 for 2 cycles (MIN_WIDTH=3) -> width_last=2, short_pulse=1 coincident with width_valid; rise_cnt increments by 1.
- CNT_W=4, apply 17 pulses of 4 cycles each -> rise_cnt stops at 15; width_last=4 after every pulse.
- q_in=1 for 300 cycles with CNT_W=8 -> width_last=255 (saturated), short_pulse=0.
- Drop reset_n mid-pulse with q_in high -> all outputs 0 before the next clk edge. Release with q_in still high -> one rise_pulse, rise_cnt=1; a later fall reports width measured from release.
- Assert clr in the cycle rise_ev is true (rise_cnt previously 3) -> rise_cnt=0, FSM S_IDLE, no rise_pulse. The following fall gives fall_pulse=1 and width_valid=0.
